// File: rtl/hmi_pkg.sv
// Shared types and default timing constants for the push-button filter.
package hmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_DN,
    ST_HELD,
    ST_REPEAT,
    ST_DB_UP
  } key_state_e;

  localparam int TICK_DIV_DEF   = 50000;
  localparam int DB_TICKS_DEF   = 20;
  localparam int RPT_DELAY_DEF  = 500;
  localparam int RPT_PERIOD_DEF = 100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key: 2-flop synchronizer, debounce/auto-repeat FSM and its tick counter.
// All outputs registered; state only advances on tick_i cycles.
module key_chan
  import hmi_pkg::*;
#(
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int CNT_MAX = max3(DB_TICKS, RPT_DELAY, RPT_PERIOD);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 1);

  logic [1:0]    sync_q;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          from_rpt_q, from_rpt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rpt_q, rpt_d;
  logic          pressed;

  assign pressed = ~sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_rpt_d = from_rpt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            if (DB_TICKS <= 1) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              press_d = 1'b1;
              level_d = 1'b1;
            end else begin
              state_d = ST_DB_DN;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_DB_DN: begin
          if (!pressed) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD, ST_REPEAT: begin
          if (!pressed) begin
            // Remember where we came from so a bounce during release resumes it.
            from_rpt_d = (state_q == ST_REPEAT);
            if (DB_TICKS <= 1) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              release_d = 1'b1;
              level_d   = 1'b0;
            end else begin
              state_d = ST_DB_UP;
              cnt_d   = CW'(1);
            end
          end else if (cnt_q == ((state_q == ST_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DB_UP: begin
          if (pressed) begin
            state_d = from_rpt_q ? ST_REPEAT : ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end
    rpt_d = (state_d == ST_REPEAT);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      from_rpt_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], key_n_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_rpt_q <= from_rpt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      rpt_q      <= rpt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign rpt_o     = rpt_q;

endmodule

// File: rtl/key_filter.sv
// Three-key debounce/auto-repeat filter: shared sample-tick prescaler feeding one key_chan per key.
// Outputs registered inside each channel; no backpressure.
module key_filter
  import hmi_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [2:0] key_in,
  output logic [2:0] key_level,
  output logic [2:0] key_press,
  output logic [2:0] key_release,
  output logic [2:0] key_rpt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    key_chan #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_chan (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .key_n_i  (key_in[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .rpt_o    (key_rpt[g])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter with small timing parameters.
module tb_key_filter;

  localparam int TD = 4;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] key_in  = 3'b111;
  logic [2:0] key_level, key_press, key_release, key_rpt;

  key_filter #(
    .TICK_DIV  (4),
    .DB_TICKS  (3),
    .RPT_DELAY (10),
    .RPT_PERIOD(5)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_rpt    (key_rpt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] level;
    logic [2:0] rpt;
    int         tick;
  } exp_t;

  exp_t sb[$];
  int checks  = 0;
  int passed  = 0;
  int cyc     = 0;
  int tick_no = 0;

  // Independent tick reference: the tick edge is every TD-th edge after reset.
  always @(posedge clk_sys) begin
    if (!rst_n) cyc = 0;
    else begin
      cyc++;
      if (cyc % TD == 0) tick_no++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
  endtask

  task automatic expect_ev(input logic [2:0] p, input logic [2:0] r, input logic [2:0] l,
                           input logic [2:0] rp, input int tk);
    exp_t e;
    e.press = p; e.rel = r; e.level = l; e.rpt = rp; e.tick = tk;
    sb.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_no + n;
    while (tick_no < t) @(negedge clk_sys);
  endtask

  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (rst_n && (key_press != 3'b000 || key_release != 3'b000)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {key_press, key_release}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("press", key_press, e.press);
        check("release", key_release, e.rel);
        check("level", key_level, e.level);
        check("rpt", key_rpt, e.rpt);
        check("event_tick", tick_no, e.tick);
        check("press_release_overlap", key_press & key_release, 32'h0);
      end
    end
  end

  initial begin
    int k, kr, bad, w;
    rst_n  = 1'b0;
    key_in = 3'b111;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {key_level, key_press, key_release, key_rpt}, 32'h0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if ({key_level, key_press, key_release, key_rpt} != 12'h0) bad++;
    end
    check("idle_quiet_100", bad, 0);

    // Single clean press and release on key 0.
    wait_ticks(1);
    k = tick_no; key_in = 3'b110;
    expect_ev(3'b001, 3'b000, 3'b001, 3'b000, k + 3);
    wait_ticks(3);
    check("s1_level_pressed", key_level, 3'b001);
    k = tick_no; key_in = 3'b111;
    expect_ev(3'b000, 3'b001, 3'b000, 3'b000, k + 3);
    wait_ticks(3);
    check("s1_level_released", key_level, 3'b000);
    wait_ticks(2);

    // Bounce: low 2, high 1, low 3.
    k = tick_no; key_in = 3'b110;
    expect_ev(3'b001, 3'b000, 3'b001, 3'b000, k + 6);
    wait_ticks(2); key_in = 3'b111;
    wait_ticks(1); key_in = 3'b110;
    wait_ticks(3);
    k = tick_no; key_in = 3'b111;
    expect_ev(3'b000, 3'b001, 3'b000, 3'b000, k + 3);
    wait_ticks(5);

    // Auto-repeat on key 1 held for 30 ticks.
    k = tick_no; key_in = 3'b101;
    expect_ev(3'b010, 3'b000, 3'b010, 3'b000, k + 3);
    for (int i = 0; i < 4; i++)
      expect_ev(3'b010, 3'b000, 3'b010, 3'b010, k + 13 + 5 * i);
    wait_ticks(30);
    key_in = 3'b111;
    expect_ev(3'b000, 3'b010, 3'b000, 3'b000, k + 33);
    wait_ticks(3);
    check("s3_rpt_off", key_rpt, 3'b000);
    wait_ticks(2);

    // Simultaneous press on keys 0 and 2, then a 1-tick glitch while held.
    k = tick_no; key_in = 3'b010;
    expect_ev(3'b101, 3'b000, 3'b101, 3'b000, k + 3);
    wait_ticks(5); key_in = 3'b111;
    wait_ticks(1); key_in = 3'b010;
    check("s4_glitch_level", key_level, 3'b101);
    wait_ticks(4); key_in = 3'b111;
    expect_ev(3'b000, 3'b101, 3'b000, 3'b000, k + 13);
    wait_ticks(5);

    // Reset pulse while key 1 is in REPEAT.
    k = tick_no; key_in = 3'b101;
    expect_ev(3'b010, 3'b000, 3'b010, 3'b000, k + 3);
    expect_ev(3'b010, 3'b000, 3'b010, 3'b010, k + 13);
    wait_ticks(14);
    check("s5_rpt_before_reset", key_rpt, 3'b010);
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    check("s5_reset_clear", {key_level, key_press, key_release, key_rpt}, 32'h0);
    kr = tick_no;
    expect_ev(3'b010, 3'b000, 3'b010, 3'b000, kr + 3);
    wait_ticks(3);
    key_in = 3'b111;
    expect_ev(3'b000, 3'b010, 3'b000, 3'b000, kr + 6);
    wait_ticks(5);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
